kbd_key_display: RTL
====================

Name: kbd_key_display

Overview:
- Registered, parametrised keyboard-to-7-segment display stage.
- Sits after the PS/2 receiver and the scancode-to-ASCII lookup ROMs.
- Tracks the make/break state of the most recent key, latches its ASCII code (shift-aware), and shows it in hex on DATA_W/4 digits.
- Counts distinct key presses, excluding auto-repeat, and shows the count on CNT_W/4 digits.

Parameters:
- DATA_W, 8: ASCII code width; must be a multiple of 4; gives DATA_W/4 display digits.
- CNT_W, 8: press-counter width; must be a multiple of 4; gives CNT_W/4 display digits.
- BRK_CODE, 8'hF0: break-prefix scancode.
- EXT_CODE, 8'hE0: extended-prefix scancode, ignored.

Ports:
- clk  in  1  system clock
- clrn  in  1  asynchronous active-low reset
- kb_valid  in  1  one-cycle strobe; kb_data is valid this cycle
- kb_data  in  8  scancode byte from the PS/2 receiver
- ascii_lo  in  DATA_W  unshifted ASCII for kb_data (combinational lookup)
- ascii_hi  in  DATA_W  shifted ASCII for kb_data
- shift  in  1  shift modifier level, sampled with kb_valid
- seg_ascii  out  7*DATA_W/4  hex digits of the latched ASCII; digit i = bits [7i+6:7i]; digit 0 = least-significant nibble
- seg_cnt  out  7*CNT_W/4  hex digits of press_cnt, same packing
- press_cnt  out  CNT_W  number of distinct presses
- key_held  out  1  high while a key is considered held

Behaviour:
- Segment code: active-low, bit6=g … bit0=a, standard team hex font.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Blank = 1111111.
- All outputs are registered. A byte sampled with kb_valid at edge N is reflected on the outputs after edge N (1-cycle latency).
- When kb_valid=0, no state changes.
- Internal registers: code_q[7:0], ascii_q[DATA_W-1:0], brk_from_held (1 bit).
- States: S_IDLE, S_HELD, S_BREAK.
- Byte classes:
  - "make": kb_data not BRK_CODE and not EXT_CODE.
  - EXT_CODE: ignored in every state, with no output change.
- S_IDLE:
  - make -> latch code_q=kb_data and ascii_q=(shift ? ascii_hi : ascii_lo); press_cnt+1; go to S_HELD.
  - BRK_CODE -> brk_from_held=0; go to S_BREAK.
- S_HELD:
  - make equal to code_q (auto-repeat) -> re-latch ascii_q with the current shift; no count change.
  - make different from code_q (rollover) -> latch the new code and ASCII; press_cnt+1; stay in S_HELD.
  - BRK_CODE -> brk_from_held=1; go to S_BREAK.
- S_BREAK: the next non-EXT byte is consumed as the release code, with no count change.
  - If brk_from_held=1 and the byte equals code_q -> S_IDLE.
  - Otherwise -> return to S_HELD if brk_from_held=1, else S_IDLE.
  - A second BRK_CODE while in S_BREAK is consumed as a release code.
- key_held = (state==S_HELD) or (state==S_BREAK and brk_from_held).
- seg_ascii:
  - Shows the hex of ascii_q while key_held=1.
  - All digits blank when key_held=0.
  - All digits blank when ascii_q==0 (unmapped key); press_cnt still increments in that case.
- press_cnt wraps modulo 2^CNT_W (all-ones + 1 -> 0).
- seg_cnt always shows press_cnt in hex.
- Reset (clrn=0, asynchronous, any state):
  - state=S_IDLE; code_q=0, ascii_q=0, brk_from_held=0, press_cnt=0, key_held=0.
  - seg_ascii all 1s (blank); seg_cnt all digits "0" (1000000).
  - Reset mid-sequence discards any pending break.

Optional Feature:
- KBD_LZ_BLANK_EN defined: leading-zero digits of seg_cnt are blanked. Digit 0 is always shown, so a count of 0 shows a single "0". A count of 8'h05 with CNT_W=8 shows blank,"5".
- Undefined: all seg_cnt digits are always shown.

Test Plan:
- Reset, then idle -> seg_ascii=all 1s, seg_cnt={1000000,1000000}, press_cnt=0, key_held=0.
- kb_valid with 8'h1C, ascii_lo=8'h61, shift=0 -> next cycle: key_held=1, seg_ascii={0000010 "6", 1111001 "1"}, press_cnt=1. Then bytes F0,1C -> key_held=0, seg_ascii blank, press_cnt stays 1.
- 8'h1C sent three times (auto-repeat) with shift=1 and ascii_hi=8'h41 -> press_cnt=1, seg_ascii="41"; then 8'h32 -> press_cnt=2, seg_ascii shows the new code.
- Rollover: 1C, 32, F0,1C -> still held showing 32's ASCII; then F0,32 -> blank, key_held=0.
- press_cnt preloaded to 8'hFF via 255 presses, then one more press -> press_cnt=0, seg_cnt="00". E0 bytes interleaved anywhere cause no state, count or output change.
- clrn pulsed low between F0 and its release byte -> immediate reset values. A following 1C is treated as a fresh press (press_cnt=1).

Source files
------------

// File: rtl/kbd_key_display.sv
// kbd_key_display: PS/2 key tracker with hex 7-segment display of ASCII and press count.
// Optional: define KBD_LZ_BLANK_EN to blank leading-zero digits of seg_cnt.
module kbd_key_display #(
    parameter int          DATA_W   = 8,
    parameter int          CNT_W    = 8,
    parameter logic [7:0]  BRK_CODE = 8'hF0,
    parameter logic [7:0]  EXT_CODE = 8'hE0
) (
    input  logic                    clk,
    input  logic                    clrn,
    input  logic                    kb_valid,
    input  logic [7:0]              kb_data,
    input  logic [DATA_W-1:0]       ascii_lo,
    input  logic [DATA_W-1:0]       ascii_hi,
    input  logic                    shift,
    output logic [7*DATA_W/4-1:0]   seg_ascii,
    output logic [7*CNT_W/4-1:0]    seg_cnt,
    output logic [CNT_W-1:0]        press_cnt,
    output logic                    key_held
);

    localparam int ND = DATA_W / 4;
    localparam int NC = CNT_W / 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

`ifdef KBD_LZ_BLANK_EN
    localparam logic [7*NC-1:0] SEG_CNT_RST =
        ({NC{SEG_BLANK}} << 7) | {{(7*NC-7){1'b0}}, SEG_ZERO};
`else
    localparam logic [7*NC-1:0] SEG_CNT_RST = {NC{SEG_ZERO}};
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_HELD,
        S_BREAK
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          code_q, code_d;
    logic [DATA_W-1:0]   ascii_q, ascii_d;
    logic                brk_q, brk_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                held_d;
    logic [7*ND-1:0]     seg_ascii_d;
    logic [7*NC-1:0]     seg_cnt_d;
    logic [DATA_W-1:0]   ascii_sel;
    logic                is_brk;
    logic                is_ext;
    logic                lead;
    logic [3:0]          nib;

    // Active-low hex font, bit6=g .. bit0=a
    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Next-state: key tracking, ASCII latch and press counting
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        ascii_d   = ascii_q;
        brk_d     = brk_q;
        cnt_d     = press_cnt;
        ascii_sel = shift ? ascii_hi : ascii_lo;
        is_brk    = (kb_data == BRK_CODE);
        is_ext    = (kb_data == EXT_CODE);
        if (kb_valid && !is_ext) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_brk) begin
                        brk_d   = 1'b0;
                        state_d = S_BREAK;
                    end else begin
                        code_d  = kb_data;
                        ascii_d = ascii_sel;
                        cnt_d   = press_cnt + 1'b1;
                        state_d = S_HELD;
                    end
                end
                S_HELD: begin
                    if (is_brk) begin
                        brk_d   = 1'b1;
                        state_d = S_BREAK;
                    end else if (kb_data == code_q) begin
                        ascii_d = ascii_sel;
                    end else begin
                        code_d  = kb_data;
                        ascii_d = ascii_sel;
                        cnt_d   = press_cnt + 1'b1;
                    end
                end
                S_BREAK: begin
                    // A release of some other key while one is held keeps it held
                    if (brk_q && kb_data != code_q)
                        state_d = S_HELD;
                    else
                        state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Next display values, computed from next state so outputs stay 1-cycle
    always_comb begin
        held_d = (state_d == S_HELD) || (state_d == S_BREAK && brk_d);
        for (int i = 0; i < ND; i++) begin
            if (!held_d || ascii_d == '0)
                seg_ascii_d[7*i +: 7] = SEG_BLANK;
            else
                seg_ascii_d[7*i +: 7] = hex7(ascii_d[4*i +: 4]);
        end
        lead = 1'b1;
        nib  = 4'd0;
        for (int i = NC - 1; i >= 0; i--) begin
            nib = cnt_d[4*i +: 4];
            if (nib != 4'd0 || i == 0)
                lead = 1'b0;
`ifdef KBD_LZ_BLANK_EN
            seg_cnt_d[7*i +: 7] = lead ? SEG_BLANK : hex7(nib);
`else
            seg_cnt_d[7*i +: 7] = hex7(nib);
`endif
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q   <= S_IDLE;
            code_q    <= '0;
            ascii_q   <= '0;
            brk_q     <= 1'b0;
            press_cnt <= '0;
            key_held  <= 1'b0;
            seg_ascii <= {ND{SEG_BLANK}};
            seg_cnt   <= SEG_CNT_RST;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            ascii_q   <= ascii_d;
            brk_q     <= brk_d;
            press_cnt <= cnt_d;
            key_held  <= held_d;
            seg_ascii <= seg_ascii_d;
            seg_cnt   <= seg_cnt_d;
        end
    end

endmodule
